table_sweep: RTL

Sequential reader for a generated lookup-table model. It drives the table's `addr` input through every entry from 0 to 2^addr_bits−1 and waits the table's read latency. It registers the returned real, signed and unsigned outputs, then presents each entry on a valid/ready output stream with back-pressure. It sits between a table model instance and a downstream consumer (checker, logger or host-interface FIFO) and also reports a running checksum of the unsigned column.

---
 rtl/table_sweep_pkg.sv | 19 +
 rtl/table_sweep.sv | 125 ++++++++++++
 2 files changed

// File: rtl/table_sweep_pkg.sv
// Shared state encoding and sizing helpers for the table_sweep lookup-table reader.
package table_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAPTURE,
        PRESENT,
        DONE
    } state_t;

    localparam int LAT_W = 3;

    // Width that holds the sum of every entry of a full sweep without overflow.
    function automatic int sum_width(input int addr_bits, input int uint_bits);
        return addr_bits + uint_bits;
    endfunction

endpackage

// File: rtl/table_sweep.sv
// Walks a latency-L lookup table from address 0 to all-ones, presenting each
// captured entry on a valid/ready stream and accumulating the unsigned column.
module table_sweep
    import table_sweep_pkg::*;
#(
    parameter int addr_bits      = 1,
    parameter int sint_bits      = 1,
    parameter int uint_bits      = 1,
    parameter int real_range     = 10,
    parameter int real_frac_bits = 8,
    parameter int real_width     = $clog2(real_range + 1) + real_frac_bits + 1,
    parameter int read_latency   = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    output logic                                        busy,
    output logic                                        done,
    output logic [addr_bits-1:0]                        addr,
    input  logic signed [real_width-1:0]                real_in,
    input  logic signed [sint_bits-1:0]                 sint_in,
    input  logic [uint_bits-1:0]                        uint_in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [addr_bits-1:0]                        out_addr,
    output logic signed [real_width-1:0]                out_real,
    output logic signed [sint_bits-1:0]                 out_sint,
    output logic [uint_bits-1:0]                        out_uint,
    output logic [sum_width(addr_bits, uint_bits)-1:0]  uint_sum
);

    localparam int SUM_W = sum_width(addr_bits, uint_bits);
    localparam logic [addr_bits-1:0] ADDR_LAST = '1;
    // Counter value on the final WAIT cycle; unused when the table is combinational.
    localparam logic [LAT_W-1:0] LAT_LAST = (read_latency == 0) ? '0 : LAT_W'(read_latency - 1);

    state_t                         state_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           valid_q;
    logic [LAT_W-1:0]               cnt_q;
    logic [addr_bits-1:0]           addr_q;
    logic [addr_bits-1:0]           out_addr_q;
    logic signed [real_width-1:0]   out_real_q;
    logic signed [sint_bits-1:0]    out_sint_q;
    logic [uint_bits-1:0]           out_uint_q;
    logic [SUM_W-1:0]               sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            out_addr_q <= '0;
            out_real_q <= '0;
            out_sint_q <= '0;
            out_uint_q <= '0;
            sum_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q <= '0;
                        sum_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (read_latency == 0) state_q <= CAPTURE;
                        else                   state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == LAT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + LAT_W'(1);
                    end
                end
                CAPTURE: begin
                    out_addr_q <= addr_q;
                    out_real_q <= real_in;
                    out_sint_q <= sint_in;
                    out_uint_q <= uint_in;
                    valid_q    <= 1'b1;
                    state_q    <= PRESENT;
                end
                PRESENT: begin
                    // out_* only reload in CAPTURE, so they stay frozen while stalled here.
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        sum_q   <= sum_q + SUM_W'(out_uint_q);
                        if (addr_q == ADDR_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q <= addr_q + addr_bits'(1);
                            if (read_latency == 0) state_q <= CAPTURE;
                            else                   state_q <= WAIT;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign addr      = addr_q;
    assign out_valid = valid_q;
    assign out_addr  = out_addr_q;
    assign out_real  = out_real_q;
    assign out_sint  = out_sint_q;
    assign out_uint  = out_uint_q;
    assign uint_sum  = sum_q;

endmodule
